// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared control types for the in-order pipeline hazard controller.
// Stage enable / bubble bundles and the controller state encoding.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } ld_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } fl_t;

  localparam ld_t LD_ALL  = 5'b11111;
  localparam ld_t LD_HOLD = 5'b00111;
  localparam ld_t LD_NONE = 5'b00000;

  localparam fl_t FL_NONE  = 4'b0000;
  localparam fl_t FL_FRONT = 4'b1100;
  localparam fl_t FL_IDEX  = 4'b0100;
  localparam fl_t FL_ALL   = 4'b1111;

  localparam logic [1:0] DRAIN_LAST = 2'd3;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running event counter with synchronous clear.
// Wraps silently at the top of its range.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: memory stalls, redirects,
// fences and load-use interlocks, plus stall/flush counters.
module pipeline_hazard_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_resp,
  input  logic        br_mispredict,
  input  logic        fence_req,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  output logic        pc_load,
  output logic        if_id_load,
  output logic        id_ex_load,
  output logic        ex_mem_load,
  output logic        mem_wb_load,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        fence_ack,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  ctrl_state_t state_q, state_d;
  logic [1:0]  drain_q, drain_d;

  logic if_stall, mem_stall, g_stall;
  logic load_use;
  logic sel_br, sel_fence, sel_lu;
  logic flush_inc;
  ld_t  ld;
  fl_t  fl;

  assign if_stall  = imem_read & ~imem_resp;
  assign mem_stall = (dmem_read | dmem_write) & ~dmem_resp;
  assign g_stall   = if_stall | mem_stall;

  assign load_use = ex_is_load & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // One-hot priority select for the RUN-side decode
  assign sel_br    = br_mispredict;
  assign sel_fence = fence_req & ~br_mispredict;
  assign sel_lu    = load_use & ~fence_req & ~br_mispredict;

  always_comb begin
    ld        = LD_ALL;
    fl        = FL_NONE;
    fence_ack = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    drain_d   = drain_q;
    if (rst) begin
      fl      = FL_ALL;
      state_d = RUN;
      drain_d = '0;
    end else if (g_stall) begin
      ld = LD_NONE;
      if (state_q != DRAIN) state_d = STALL;
    end else if (state_q == DRAIN) begin
      if (br_mispredict) begin
        fl        = FL_FRONT;
        flush_inc = 1'b1;
        drain_d   = '0;
        state_d   = RUN;
      end else begin
        ld = LD_HOLD;
        fl = FL_IDEX;
        if (drain_q == DRAIN_LAST) begin
          fence_ack = 1'b1;
          drain_d   = '0;
          state_d   = RUN;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
    end else begin
      // STALL released this cycle behaves exactly like RUN
      state_d = RUN;
      unique case (1'b1)
        sel_br: begin
          fl        = FL_FRONT;
          flush_inc = 1'b1;
        end
        sel_fence: begin
          ld      = LD_HOLD;
          fl      = FL_IDEX;
          drain_d = 2'd1;
          state_d = DRAIN;
        end
        sel_lu: begin
          ld = LD_HOLD;
          fl = FL_IDEX;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign pc_load      = ld.pc;
  assign if_id_load   = ld.if_id;
  assign id_ex_load   = ld.id_ex;
  assign ex_mem_load  = ld.ex_mem;
  assign mem_wb_load  = ld.mem_wb;
  assign if_id_flush  = fl.if_id;
  assign id_ex_flush  = fl.id_ex;
  assign ex_mem_flush = fl.ex_mem;
  assign mem_wb_flush = fl.mem_wb;
  assign ctrl_state   = state_q;

  perf_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (g_stall),
    .cnt_o (stall_cnt)
  );

  perf_counter #(.W(32)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized checks of pipeline_hazard_ctrl
// against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic imem_read, imem_resp;
  logic dmem_read, dmem_write, dmem_resp;
  logic br_mispredict, fence_req;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_is_load;
  logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic fence_ack;
  logic [1:0] ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // model: mode 0=run 1=stalled 2=draining
  int m_mode;
  int m_left;
  logic [31:0] m_stalls, m_flushes;

  logic [4:0]  obs_ld;
  logic [3:0]  obs_fl;
  logic        obs_ack;
  logic [1:0]  obs_st;
  logic [31:0] obs_sc, obs_fc;
  logic [7:0]  ack_hist;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_resp(dmem_resp),
    .br_mispredict(br_mispredict), .fence_req(fence_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load),
    .pc_load(pc_load), .if_id_load(if_id_load),
    .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
    .mem_wb_load(mem_wb_load),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .fence_ack(fence_ack), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit stalled_now();
    return (imem_read && !imem_resp) ||
           ((dmem_read || dmem_write) && !dmem_resp);
  endfunction

  function automatic bit hazard_now();
    return ex_is_load && ex_rd != 0 &&
           (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  // expected {pc,ifid,idex,exmem,memwb}, {ifid,idex,exmem,memwb}, ack
  task automatic model_out(output logic [4:0] el,
                           output logic [3:0] ef,
                           output logic ea);
    ea = 1'b0;
    if (rst) begin
      el = 5'b11111; ef = 4'b1111;
    end else if (stalled_now()) begin
      el = 5'b00000; ef = 4'b0000;
    end else if (br_mispredict) begin
      el = 5'b11111; ef = 4'b1100;
    end else if (m_mode == 2) begin
      el = 5'b00111; ef = 4'b0100;
      ea = (m_left == 0);
    end else if (fence_req || hazard_now()) begin
      el = 5'b00111; ef = 4'b0100;
    end else begin
      el = 5'b11111; ef = 4'b0000;
    end
  endtask

  task automatic model_next();
    if (rst) begin
      m_mode = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
    end else if (stalled_now()) begin
      m_stalls++;
      if (m_mode != 2) m_mode = 1;
    end else if (br_mispredict) begin
      m_flushes++;
      m_mode = 0;
    end else if (m_mode == 2) begin
      if (m_left == 0) m_mode = 0;
      else m_left--;
    end else if (fence_req) begin
      m_mode = 2;
      m_left = 2;
    end else begin
      m_mode = 0;
    end
  endtask

  task automatic step();
    logic [4:0] el;
    logic [3:0] ef;
    logic ea;
    #2;
    model_out(el, ef, ea);
    obs_ld  = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
    obs_fl  = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    obs_ack = fence_ack;
    obs_st  = ctrl_state;
    obs_sc  = stall_cnt;
    obs_fc  = flush_cnt;
    chk("loads", 32'(obs_ld), 32'(el));
    chk("flushes", 32'(obs_fl), 32'(ef));
    chk("fence_ack", 32'(obs_ack), 32'(ea));
    chk("state", 32'(obs_st), 32'(m_mode));
    chk("stall_cnt", obs_sc, m_stalls);
    chk("flush_cnt", obs_fc, m_flushes);
    chk("flush_wo_load", 32'(obs_fl & ~obs_ld[3:0] |
        {obs_fl[3] & ~obs_ld[3], 3'b0}), 32'(rst ? 0 :
        (obs_fl & ~obs_ld[3:0])));
    @(posedge clk);
    model_next();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_read = 0; imem_resp = 0;
    dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    br_mispredict = 0; fence_req = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_is_load = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    chk("rst_flushes", 32'(obs_fl), 32'hf);
    chk("rst_loads", 32'(obs_ld), 32'h1f);
    rst = 0;
  endtask

  initial begin
    m_mode = 0; m_left = 0; m_stalls = 0; m_flushes = 0;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    step();
    rst = 0;
    step();
    chk("reset_state", 32'(obs_st), 32'd0);
    chk("reset_stall_cnt", obs_sc, 32'd0);
    chk("reset_flush_cnt", obs_fc, 32'd0);

    // load-use on rs2
    ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 3;
    step();
    chk("lu_pc_if_hold", 32'(obs_ld[4:3]), 32'd0);
    chk("lu_idex_flush", 32'(obs_fl[2]), 32'd1);
    ex_is_load = 0;
    step();
    chk("lu_release", 32'(obs_ld), 32'h1f);

    // x0 destination never interlocks
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
    step();
    chk("lu_x0", 32'(obs_ld), 32'h1f);
    idle_inputs();

    // dmem stall of 4 cycles
    do_reset();
    dmem_read = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dstall_loads", 32'(obs_ld), 32'd0);
    end
    dmem_resp = 1;
    step();
    chk("dstall_rel_loads", 32'(obs_ld), 32'h1f);
    chk("dstall_rel_state", 32'(obs_st), 32'd1);
    idle_inputs();
    step();
    chk("dstall_cnt", obs_sc, 32'd3);
    chk("dstall_run", 32'(obs_st), 32'd0);

    // mispredict beats load-use
    do_reset();
    br_mispredict = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7;
    step();
    chk("br_lu_flush", 32'(obs_fl), 32'hc);
    chk("br_lu_loads", 32'(obs_ld), 32'h1f);
    idle_inputs();
    step();
    chk("br_lu_fcnt", obs_fc, 32'd1);

    // fence with dmem stall in 2nd drain cycle
    do_reset();
    ack_hist = '0;
    for (int c = 0; c < 8; c++) begin
      fence_req = (c <= 5);
      dmem_read = (c == 2 || c == 3);
      step();
      ack_hist[c] = obs_ack;
    end
    idle_inputs();
    chk("fence_ack_cycle", 32'(ack_hist), 32'h20);

    // mispredict in 1st drain cycle
    do_reset();
    fence_req = 1;
    step();
    br_mispredict = 1;
    step();
    chk("abort_no_ack", 32'(obs_ack), 32'd0);
    idle_inputs();
    step();
    chk("abort_state", 32'(obs_st), 32'd0);
    chk("abort_fcnt", obs_fc, 32'd1);
    step();
    chk("abort_no_late_ack", 32'(obs_ack), 32'd0);

    // reset while draining
    do_reset();
    imem_read = 1;
    for (int i = 0; i < 7; i++) step();
    imem_read = 0; fence_req = 1;
    step();
    chk("pre_rst_scnt", obs_sc, 32'd7);
    step();
    chk("pre_rst_drain", 32'(obs_st), 32'd2);
    rst = 1;
    step();
    chk("rst_drain_fl", 32'(obs_fl), 32'hf);
    chk("rst_drain_ack", 32'(obs_ack), 32'd0);
    rst = 0; fence_req = 0;
    step();
    chk("post_rst_state", 32'(obs_st), 32'd0);
    chk("post_rst_scnt", obs_sc, 32'd0);
    chk("post_rst_fcnt", obs_fc, 32'd0);
    chk("post_rst_loads", 32'(obs_ld), 32'h1f);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      imem_read     = ($urandom_range(0, 3) == 0);
      imem_resp     = $urandom_range(0, 1) == 1;
      dmem_read     = ($urandom_range(0, 4) == 0);
      dmem_write    = ($urandom_range(0, 5) == 0);
      dmem_resp     = $urandom_range(0, 1) == 1;
      br_mispredict = ($urandom_range(0, 7) == 0);
      fence_req     = (m_mode == 2) ? 1'b1
                      : ($urandom_range(0, 9) == 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_is_load    = $urandom_range(0, 1) == 1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: imem_read  in  1  fetch outstanding; imem_resp  in  1  fetch complete.
REQ-004 SHALL have: dmem_read, dmem_write  in  1 each  MEM-stage access outstanding; dmem_resp  in  1  access complete.
REQ-005 SHALL have: br_mispredict  in  1  EX-stage redirect.
REQ-006 SHALL have: fence_req  in  1  ID-stage fence, held high until fence_ack.
REQ-007 SHALL have: id_rs1, id_rs2  in  5 each; ex_rd  in  5; ex_is_load  in  1.
REQ-008 SHALL have: pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  stage-register load enables.
REQ-009 SHALL have: if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  bubble insert, effective only with matching load high.
REQ-010 SHALL have: fence_ack  out  1  one-cycle pulse; ctrl_state  out  2  current FSM state.
REQ-011 SHALL have: stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-012 SHALL define if_stall = imem_read & ~imem_resp, mem_stall = (dmem_read | dmem_write) & ~dmem_resp, g_stall = if_stall | mem_stall.
REQ-013 SHALL define load_use = ex_is_load & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-014 SHALL implement FSM states RUN, STALL, DRAIN; all load/flush outputs combinational from state and inputs, zero-latency.
REQ-015 SHALL, any state with g_stall: all five loads 0, all flushes 0; RUN/STALL go to STALL next; DRAIN stays DRAIN with drain counter held.
REQ-016 SHALL, STALL with ~g_stall: evaluate as RUN in the same cycle (release cycle not lost).
REQ-017 SHALL, RUN/STALL without g_stall, apply priority: br_mispredict > fence_req > load_use > normal.
REQ-018 SHALL, mispredict: all loads 1, if_id_flush = id_ex_flush = 1, flush_cnt += 1, next RUN.
REQ-019 SHALL, fence_req: pc_load = 0, if_id_load = 0, id_ex_load = id_ex_flush = 1, ex_mem_load = mem_wb_load = 1, drain counter <= 1, next DRAIN.
REQ-020 SHALL, load_use: pc_load = if_id_load = 0, id_ex_load = id_ex_flush = 1, ex_mem_load = mem_wb_load = 1, next RUN.
REQ-021 SHALL, normal: all loads 1, all flushes 0, next RUN.
REQ-022 SHALL, DRAIN without g_stall: same outputs as REQ-019; drain counter (2-bit) increments; at count 3 assert fence_ack, next RUN, counter <= 0.
REQ-023 SHALL, br_mispredict in DRAIN without g_stall: abort drain, outputs per REQ-018, no fence_ack, counter <= 0, next RUN.
REQ-024 SHALL never assert any flush with its load low; ex_mem_flush and mem_wb_flush SHALL be 0 except while rst is high.
REQ-025 SHALL increment stall_cnt on every cycle with g_stall; both counters wrap 2^32-1 -> 0.
REQ-026 SHALL keep fence_ack low in all states except per REQ-022.

Reset
REQ-027 SHALL, while rst high: state <= RUN, drain counter, stall_cnt, flush_cnt <= 0.
REQ-028 SHALL, while rst high: all loads 1, all four flushes 1, fence_ack 0, so every stage register clears on that edge.
REQ-029 SHALL, rst mid-DRAIN or mid-STALL: abandon operation, no fence_ack, normal RUN behaviour from first cycle after rst deasserts.

Structure
REQ-030 SHALL place ctrl_state_t enum (RUN = 0, STALL = 1, DRAIN = 2) in package rv32i_types.
REQ-031 SHALL instantiate sub-module perf_counter (32-bit, synchronous clear, enable-increment, wrap) twice for stall_cnt and flush_cnt.
REQ-032 SHALL keep hazard decode (REQ-012/013) inline; no other sub-modules.

Verification
REQ-033 SHALL test load-use: ex_is_load = 1, ex_rd = 5, id_rs2 = 5 -> one cycle pc_load = if_id_load = 0, id_ex_flush = 1; next cycle (ex_is_load = 0) all loads 1.
REQ-034 SHALL test dmem stall: dmem_read = 1 for 4 cycles, dmem_resp in 4th -> loads 0 for 3 cycles, loads 1 in 4th, stall_cnt = 3, ctrl_state STALL then RUN.
REQ-035 SHALL test mispredict plus load_use same cycle -> if_id_flush = id_ex_flush = 1, all loads 1, flush_cnt = 1.
REQ-036 SHALL test fence with dmem stall in 2nd DRAIN cycle for 2 cycles -> fence_ack exactly on 5th cycle after fence_req rises, single pulse.
REQ-037 SHALL test mispredict in 1st DRAIN cycle -> no fence_ack, state RUN, flush_cnt += 1.
REQ-038 SHALL test rst asserted in DRAIN with stall_cnt = 7 -> all flushes 1, counters 0, state RUN after deassert.
